// File: rtl/jt51_pkg.sv
// Shared constants for the jt51 mixer slice.
//   Slot timing: 32 operator slots per sample frame, noise in the last slot.
//   Datapath widths: 14-bit operator, 12-bit noise, 19-bit accumulator,
//   16-bit output, plus the output saturation limits.
package jt51_pkg;
  localparam int unsigned SLOT_COUNT = 32;
  localparam int unsigned SLOT_W     = $clog2(SLOT_COUNT);
  localparam logic [SLOT_W-1:0] NOISE_SLOT = SLOT_W'(SLOT_COUNT - 1);

  localparam int unsigned OP_W    = 14;
  localparam int unsigned NOISE_W = 12;
  localparam int unsigned ACC_W   = 19;
  localparam int unsigned OUT_W   = 16;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;
endpackage

// File: rtl/jt51_sat.sv
// Signed saturation from IW bits down to the 16-bit output range.
//   din  : signed IW-bit value
//   dout : din clamped to [SAT_MIN, SAT_MAX]
module jt51_sat
  import jt51_pkg::*;
#(
  parameter int unsigned IW = ACC_W
) (
  input  logic signed [IW-1:0]    din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic signed [IW-1:0] HI = IW'(SAT_MAX);
  localparam logic signed [IW-1:0] LO = IW'(SAT_MIN);

  always_comb begin
    dout = din[OUT_W-1:0];
    if (din > HI)
      dout = OUT_W'(SAT_MAX);
    else if (din < LO)
      dout = OUT_W'(SAT_MIN);
  end

endmodule

// File: rtl/jt51_mixer.sv
// Operator/noise mixer: accumulates carrier outputs per slot into left and
// right accumulators and emits one saturated stereo sample per 32-slot frame.
//   clk, rst_n    : clock, asynchronous active-low reset
//   cen           : slot clock enable (one operator slot per cen)
//   zero          : forces the slot counter to 0; mid-frame it discards the frame
//   op_out        : signed operator result for the current slot
//   carrier, rl   : carrier flag and left/right enables for the current slot
//   ne, noise_mix : noise enable and signed noise sample (used in slot 31)
//   op31_no       : high while the slot counter is 31
//   left, right   : signed 16-bit output samples
//   sample        : one-cen pulse when left/right update
module jt51_mixer
  import jt51_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cen,
  input  logic                      zero,
  input  logic signed [OP_W-1:0]    op_out,
  input  logic                      carrier,
  input  logic        [1:0]         rl,
  input  logic                      ne,
  input  logic signed [NOISE_W-1:0] noise_mix,
  output logic                      op31_no,
  output logic signed [OUT_W-1:0]   left,
  output logic signed [OUT_W-1:0]   right,
  output logic                      sample
);

  logic        [SLOT_W-1:0] slot;
  logic signed [OP_W-1:0]   contrib;
  logic signed [ACC_W-1:0]  contrib_ext;
  logic signed [ACC_W-1:0]  acc_l, acc_r;
  logic signed [ACC_W-1:0]  sum_l, sum_r;
  logic signed [OUT_W-1:0]  sat_l, sat_r;

  assign op31_no = (slot == NOISE_SLOT);

  // In slot 31 the noise sample replaces the operator, aligned to the
  // 14-bit operator scale by two zero LSBs.
  always_comb begin
    contrib = '0;
    if (op31_no && ne)
      contrib = {noise_mix, 2'b00};
    else if (carrier)
      contrib = op_out;
  end

  assign contrib_ext = {{(ACC_W-OP_W){contrib[OP_W-1]}}, contrib};

  // The slot-31 output includes that slot's own contribution, so the
  // saturators see the would-be accumulator value rather than the register.
  always_comb begin
    sum_l = acc_l + (rl[1] ? contrib_ext : '0);
    sum_r = acc_r + (rl[0] ? contrib_ext : '0);
  end

  jt51_sat #(.IW(ACC_W)) u_sat_l (.din(sum_l), .dout(sat_l));
  jt51_sat #(.IW(ACC_W)) u_sat_r (.din(sum_r), .dout(sat_r));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot   <= '0;
      acc_l  <= '0;
      acc_r  <= '0;
      left   <= '0;
      right  <= '0;
      sample <= 1'b0;
    end else if (cen) begin
      slot   <= zero ? '0 : slot + 1'b1;
      sample <= op31_no;
      if (op31_no) begin
        left  <= sat_l;
        right <= sat_r;
        acc_l <= '0;
        acc_r <= '0;
      end else if (zero) begin
        acc_l <= '0;
        acc_r <= '0;
      end else begin
        acc_l <= sum_l;
        acc_r <= sum_r;
      end
    end
  end

endmodule

// File: tb/tb_jt51_mixer.sv
module tb_jt51_mixer;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cen = 1'b0;
  logic               zero = 1'b0;
  logic signed [13:0] op_out = '0;
  logic               carrier = 1'b0;
  logic        [1:0]  rl = '0;
  logic               ne = 1'b0;
  logic signed [11:0] noise_mix = '0;
  logic               op31_no;
  logic signed [15:0] left, right;
  logic               sample;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_slot = 0;
  int m_acc_l = 0, m_acc_r = 0;
  int m_left = 0, m_right = 0;
  int m_sample = 0;

  // per-frame stimulus tables
  int          f_op  [32];
  bit          f_car [32];
  bit   [1:0]  f_rl  [32];
  bit          f_ne;
  int          f_noise;

  always #5 clk = ~clk;

  jt51_mixer dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .op_out(op_out),
    .carrier(carrier), .rl(rl), .ne(ne), .noise_mix(noise_mix),
    .op31_no(op31_no), .left(left), .right(right), .sample(sample)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    m_slot = 0; m_acc_l = 0; m_acc_r = 0;
    m_left = 0; m_right = 0; m_sample = 0;
  endtask

  // One slot: drive inputs, pulse cen for one clock, idle one clock.
  task automatic do_slot(input int op, input bit car, input bit [1:0] r,
                         input bit n, input int nz, input bit z);
    int c;
    @(negedge clk);
    op_out = 14'(op); carrier = car; rl = r; ne = n;
    noise_mix = 12'(nz); zero = z; cen = 1'b1;
    #1 check("op31_no", int'(op31_no), int'(m_slot == 31));
    if (m_slot == 31 && n) c = nz * 4;
    else c = car ? op : 0;
    if (m_slot == 31) begin
      m_left  = clamp16(m_acc_l + (r[1] ? c : 0));
      m_right = clamp16(m_acc_r + (r[0] ? c : 0));
      m_acc_l = 0; m_acc_r = 0; m_sample = 1;
    end else if (z) begin
      m_acc_l = 0; m_acc_r = 0; m_sample = 0;
    end else begin
      m_acc_l += r[1] ? c : 0;
      m_acc_r += r[0] ? c : 0;
      m_sample = 0;
    end
    m_slot = z ? 0 : (m_slot + 1) % 32;
    @(posedge clk); #1;
    check("sample", int'(sample), m_sample);
    if (m_sample != 0) begin
      check("left", int'(left), m_left);
      check("right", int'(right), m_right);
    end
    @(negedge clk); cen = 1'b0;
    @(posedge clk); #1;
    check("sample_hold", int'(sample), m_sample);
    check("left_hold", int'(left), m_left);
    check("right_hold", int'(right), m_right);
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 32; i++) begin
      f_op[i] = 0; f_car[i] = 1'b0; f_rl[i] = 2'b00;
    end
    f_ne = 1'b0; f_noise = 0;
  endtask

  // Runs slots from the model's current slot up to and including slot 31.
  task automatic run_frame();
    int s;
    while (m_slot != 31) begin
      s = m_slot;
      do_slot(f_op[s], f_car[s], f_rl[s], f_ne, f_noise, 1'b0);
    end
    do_slot(f_op[31], f_car[31], f_rl[31], f_ne, f_noise, 1'b0);
  endtask

  task automatic expect_out(input string tag, input int l, input int r);
    check({tag, "_l"}, int'(left), l);
    check({tag, "_r"}, int'(right), r);
  endtask

  initial begin
    #12;
    check("rst_left", int'(left), 0);
    check("rst_right", int'(right), 0);
    check("rst_sample", int'(sample), 0);
    check("rst_op31", int'(op31_no), 0);
    @(negedge clk); rst_n = 1'b1;
    model_reset();

    // single carrier in slot 5, two frames
    for (int k = 0; k < 2; k++) begin
      clear_frame();
      f_op[5] = 1000; f_car[5] = 1'b1; f_rl[5] = 2'b11;
      run_frame();
      expect_out("single", 1000, 1000);
    end

    // left/right routing
    clear_frame();
    f_op[3] = -500; f_car[3] = 1'b1; f_rl[3] = 2'b10;
    f_op[7] = 700;  f_car[7] = 1'b1; f_rl[7] = 2'b01;
    run_frame();
    expect_out("route", -500, 700);

    // noise substitution in slot 31, then without noise
    clear_frame();
    f_op[31] = 8191; f_car[31] = 1'b1; f_rl[31] = 2'b11;
    f_ne = 1'b1; f_noise = 12'h7FF;
    run_frame();
    expect_out("noise_on", 8188, 8188);
    f_ne = 1'b0;
    run_frame();
    expect_out("noise_off", 8191, 8191);

    // saturation in both directions
    clear_frame();
    for (int i = 0; i < 8; i++) begin
      f_op[i * 3] = 8191; f_car[i * 3] = 1'b1; f_rl[i * 3] = 2'b11;
    end
    run_frame();
    expect_out("sat_pos", 32767, 32767);
    for (int i = 0; i < 8; i++) f_op[i * 3] = -8192;
    run_frame();
    expect_out("sat_neg", -32768, -32768);

    // mid-frame zero at slot 12: partial frame discarded, no pulse
    clear_frame();
    for (int i = 0; i < 32; i++) begin
      f_op[i] = 300; f_car[i] = 1'b1; f_rl[i] = 2'b11;
    end
    while (m_slot != 12) do_slot(f_op[m_slot], 1'b1, 2'b11, 1'b0, 0, 1'b0);
    do_slot(300, 1'b1, 2'b11, 1'b0, 0, 1'b1);
    check("resync_slot0", m_slot, 0);
    run_frame();
    expect_out("resync", 9600, 9600);

    // asynchronous reset mid-frame
    while (m_slot != 9) do_slot(100, 1'b1, 2'b11, 1'b0, 0, 1'b0);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check("arst_left", int'(left), 0);
    check("arst_right", int'(right), 0);
    check("arst_sample", int'(sample), 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    clear_frame();
    f_op[0] = 1234; f_car[0] = 1'b1; f_rl[0] = 2'b01;
    run_frame();
    expect_out("post_rst", 0, 1234);

    // randomized frames, including noise and occasional mid-frame zero
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 32; i++) begin
        f_op[i]  = $signed(14'($urandom));
        f_car[i] = 1'($urandom_range(0, 1));
        f_rl[i]  = 2'($urandom);
      end
      f_ne = 1'($urandom_range(0, 1));
      f_noise = $signed(12'($urandom));
      if ($urandom_range(0, 5) == 0) begin
        while (m_slot < 20) begin
          do_slot(f_op[m_slot], f_car[m_slot], f_rl[m_slot], f_ne, f_noise,
                  ($urandom_range(0, 7) == 0));
          if (m_slot == 0) break;
        end
      end
      while (m_slot != 31)
        do_slot(f_op[m_slot], f_car[m_slot], f_rl[m_slot], f_ne, f_noise, 1'b0);
      do_slot(f_op[31], f_car[31], f_rl[31], f_ne, f_noise,
              1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1);
  end

endmodule
